// File: rtl/uart.sv
// Avalon-MM UART: 1-entry TX holding register feeding a shifter, 2-flop synchronised RX.
// TX start bit is driven the cycle after an accepting write; writes to address 0 stall while the holding register is full.
module uart #(
    parameter int    AAW      = 1,
    parameter int    ADW      = 32,
    parameter int    BYTESIZE = 8,
    parameter string PARITY   = "NONE",
    parameter int    STOPSIZE = 1,
    parameter int    BAUD_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 avalon_read,
    input  logic                 avalon_write,
    input  logic [AAW-1:0]       avalon_address,
    input  logic [ADW/8-1:0]     avalon_byteenable,
    input  logic [ADW-1:0]       avalon_writedata,
    output logic [ADW-1:0]       avalon_readdata,
    output logic                 avalon_waitrequest,
    input  logic                 uart_rxd,
    output logic                 uart_txd
);
    localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE  = (BAUD_DIV > 1) ? CW'(1) : '0;
    localparam bit            PAR_EN   = (PARITY != "NONE");
    localparam bit            PAR_ODD  = (PARITY == "ODD");

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // bus decode
    logic w_sel0, w_sel1, w_wr0, w_wr1, w_rd_clr, w_unused;
    logic                r_thr_full;
    logic [BYTESIZE-1:0] r_thr_dat;

    assign w_sel0             = (avalon_address == AAW'(0));
    assign w_sel1             = (avalon_address == AAW'(1));
    assign avalon_waitrequest = avalon_write & w_sel0 & r_thr_full;
    assign w_wr0              = avalon_write & w_sel0 & ~r_thr_full & avalon_byteenable[0];
    assign w_wr1              = avalon_write & w_sel1;
    assign w_rd_clr           = avalon_read & w_sel0 & avalon_byteenable[0];
    assign w_unused           = ^{avalon_byteenable, avalon_writedata};

    // ---------------- TX ----------------
    state_t              r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]       r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]          r_tx_bit, w_tx_bit_nxt;
    logic [BYTESIZE-1:0] r_tx_shift, w_tx_shift_nxt, w_tx_src;
    logic                r_tx_par, w_tx_par_nxt, r_txd, w_txd_nxt;
    logic                w_tx_last, w_tx_accept, w_tx_load;

    assign w_tx_last   = (r_tx_cnt == CNT_LAST);
    // the shifter can take a new byte on the final cycle of the last stop bit, giving gapless frames
    assign w_tx_accept = (r_tx_state == S_IDLE) |
                         ((r_tx_state == S_STOP) & w_tx_last & (r_tx_bit == 3'(STOPSIZE - 1)));
    assign w_tx_load   = w_tx_accept & (r_thr_full | w_wr0);
    assign w_tx_src    = r_thr_full ? r_thr_dat : avalon_writedata[BYTESIZE-1:0];

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_last ? '0 : r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txd_nxt      = 1'b1;
        case (r_tx_state)
            S_IDLE:  w_tx_cnt_nxt = '0;
            S_START: if (w_tx_last) begin
                w_tx_state_nxt = S_DATA;
                w_tx_bit_nxt   = '0;
            end
            S_DATA: if (w_tx_last) begin
                if (r_tx_bit == 3'(BYTESIZE - 1)) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = PAR_EN ? S_PAR : S_STOP;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit + 1'b1;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                end
            end
            S_PAR: if (w_tx_last) begin
                w_tx_state_nxt = S_STOP;
                w_tx_bit_nxt   = '0;
            end
            S_STOP: if (w_tx_last) begin
                if (r_tx_bit == 3'(STOPSIZE - 1)) w_tx_state_nxt = S_IDLE;
                else                              w_tx_bit_nxt   = r_tx_bit + 1'b1;
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_state_nxt = S_START;
            w_tx_cnt_nxt   = '0;
            w_tx_bit_nxt   = '0;
            w_tx_shift_nxt = w_tx_src;
            w_tx_par_nxt   = ^w_tx_src ^ PAR_ODD;
        end
        case (w_tx_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
            S_PAR:   w_txd_nxt = w_tx_par_nxt;
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
            r_thr_full <= 1'b0;
            r_thr_dat  <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_txd      <= w_txd_nxt;
            if (w_tx_load & r_thr_full) begin
                r_thr_full <= 1'b0;
            end else if (w_wr0 & ~w_tx_load) begin
                r_thr_full <= 1'b1;
                r_thr_dat  <= avalon_writedata[BYTESIZE-1:0];
            end
        end
    end

    assign uart_txd = r_txd;

    // ---------------- RX ----------------
    state_t              r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]       r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]          r_rx_bit, w_rx_bit_nxt;
    logic [BYTESIZE-1:0] r_rx_shift, w_rx_shift_nxt, r_rx_data;
    logic                r_rx_par, w_rx_par_nxt, r_rx_perr, w_rx_perr_nxt;
    logic                r_rx_s1, r_rx_s2, r_rx_prev;
    logic                r_rx_valid, r_rx_ovr, r_rx_ferr;
    logic                w_rx_fall, w_rx_samp, w_rx_good, w_rx_bad;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_samp = (r_rx_cnt == CNT_HALF);

    // state only advances at mid-bit sample points; the counter keeps bit-period phase
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = (r_rx_cnt == CNT_LAST) ? '0 : r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_perr_nxt  = r_rx_perr;
        w_rx_good      = 1'b0;
        w_rx_bad       = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (w_rx_fall) begin
                    w_rx_cnt_nxt  = CNT_ONE;
                    w_rx_par_nxt  = 1'b0;
                    w_rx_perr_nxt = 1'b0;
                    w_rx_bit_nxt  = '0;
                    // with a 1-cycle bit the start bit's sample point is the edge itself
                    w_rx_state_nxt = (CNT_HALF == '0) ? S_DATA : S_START;
                end
            end
            S_START: if (w_rx_samp) begin
                w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
                w_rx_bit_nxt   = '0;
            end
            S_DATA: if (w_rx_samp) begin
                w_rx_shift_nxt = {r_rx_s2, r_rx_shift[BYTESIZE-1:1]};
                w_rx_par_nxt   = r_rx_par ^ r_rx_s2;
                if (r_rx_bit == 3'(BYTESIZE - 1)) w_rx_state_nxt = PAR_EN ? S_PAR : S_STOP;
                else                              w_rx_bit_nxt   = r_rx_bit + 1'b1;
            end
            S_PAR: if (w_rx_samp) begin
                w_rx_perr_nxt  = ((r_rx_par ^ r_rx_s2) != PAR_ODD);
                w_rx_state_nxt = S_STOP;
            end
            S_STOP: if (w_rx_samp) begin
                w_rx_state_nxt = S_IDLE;
                if (!r_rx_s2 || r_rx_perr) w_rx_bad  = 1'b1;
                else                       w_rx_good = 1'b1;
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= uart_rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
            if (w_wr1 && avalon_writedata[3]) r_rx_ovr  <= 1'b0;
            if (w_wr1 && avalon_writedata[4]) r_rx_ferr <= 1'b0;
            if (w_rx_bad) r_rx_ferr <= 1'b1;
            // a new byte beats a same-cycle clearing read
            if (w_rx_good) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid) r_rx_ovr <= 1'b1;
            end else if (w_rd_clr) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        avalon_readdata = '0;
        if (w_sel0) begin
            avalon_readdata[BYTESIZE-1:0] = r_rx_data;
            avalon_readdata[8]            = r_rx_valid;
        end else if (w_sel1) begin
            avalon_readdata[4:0] = {r_rx_ferr, r_rx_ovr, r_rx_valid,
                                    (r_tx_state != S_IDLE), ~r_thr_full};
        end
    end
endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: four instances (NONE/1, EVEN/1, ODD/1, NONE/4 clocks per bit).
module tb_uart;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd[4], wr[4], wreq[4], rxd[4], txd[4];
    logic [0:0]  addr[4];
    logic [3:0]  be[4];
    logic [31:0] wd[4], rdata[4];
    int nchk = 0;
    int nerr = 0;

    uart #(.PARITY("NONE")) u_dut0 (.clk(clk), .rst(rst), .avalon_read(rd[0]), .avalon_write(wr[0]),
        .avalon_address(addr[0]), .avalon_byteenable(be[0]), .avalon_writedata(wd[0]),
        .avalon_readdata(rdata[0]), .avalon_waitrequest(wreq[0]), .uart_rxd(rxd[0]), .uart_txd(txd[0]));
    uart #(.PARITY("EVEN")) u_dut1 (.clk(clk), .rst(rst), .avalon_read(rd[1]), .avalon_write(wr[1]),
        .avalon_address(addr[1]), .avalon_byteenable(be[1]), .avalon_writedata(wd[1]),
        .avalon_readdata(rdata[1]), .avalon_waitrequest(wreq[1]), .uart_rxd(rxd[1]), .uart_txd(txd[1]));
    uart #(.PARITY("ODD")) u_dut2 (.clk(clk), .rst(rst), .avalon_read(rd[2]), .avalon_write(wr[2]),
        .avalon_address(addr[2]), .avalon_byteenable(be[2]), .avalon_writedata(wd[2]),
        .avalon_readdata(rdata[2]), .avalon_waitrequest(wreq[2]), .uart_rxd(rxd[2]), .uart_txd(txd[2]));
    uart #(.BAUD_DIV(4)) u_dut3 (.clk(clk), .rst(rst), .avalon_read(rd[3]), .avalon_write(wr[3]),
        .avalon_address(addr[3]), .avalon_byteenable(be[3]), .avalon_writedata(wd[3]),
        .avalon_readdata(rdata[3]), .avalon_waitrequest(wreq[3]), .uart_rxd(rxd[3]), .uart_txd(txd[3]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // all bus tasks start and end 1 time unit after a rising edge
    task automatic bus_write(input int k, input logic a, input logic [31:0] d,
                             input logic [3:0] b, output int nwait);
        nwait = 0;
        addr[k] = a; wd[k] = d; be[k] = b; wr[k] = 1'b1;
        #2;
        while (wreq[k] && nwait < 200) begin
            @(posedge clk); #2;
            nwait++;
        end
        @(posedge clk); #1;
        wr[k] = 1'b0;
    endtask

    task automatic bus_read(input int k, input logic a, input logic [3:0] b, output logic [31:0] q);
        addr[k] = a; be[k] = b; rd[k] = 1'b1;
        #3;
        q = rdata[k];
        @(posedge clk); #1;
        rd[k] = 1'b0;
    endtask

    // instance 3 runs at 4 clocks per bit
    task automatic send_rx(input logic [7:0] d, input logic stopb);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd[3] = f[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rxd[3] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic capture12(input int k, output logic [11:0] got);
        for (int j = 0; j < 12; j++) begin
            got[j] = txd[k];
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [11:0] exp;   // txd per cycle from the cycle after the write, bit 0 first
    } txvec_t;
    txvec_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [11:0] got;
        logic [60:0] mb;
        logic [7:0]  hello[6];
        int          hw[6];
        int          nw, fr_bad;
        logic        found, all1;

        tv[0] = '{0, 8'h48, {3'b111, 8'h48, 1'b0}};
        tv[1] = '{0, 8'hA5, {3'b111, 8'hA5, 1'b0}};
        tv[2] = '{1, 8'h48, {2'b11, 1'b0, 8'h48, 1'b0}};
        tv[3] = '{1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}};
        tv[4] = '{2, 8'h48, {2'b11, 1'b1, 8'h48, 1'b0}};
        tv[5] = '{2, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0}};
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C};

        for (int k = 0; k < 4; k++) begin
            rd[k] = 0; wr[k] = 0; addr[k] = 0; be[k] = 0; wd[k] = 0; rxd[k] = 1;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk("reset_txd", {31'b0, txd[k]}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        bus_read(0, 1'b1, 4'hF, q); chk("reset_status", q, 32'h1);
        bus_read(3, 1'b0, 4'hF, q); chk("reset_rxdata", q, 32'h0);

        // single frames, all parity modes
        for (int i = 0; i < 6; i++) begin
            bus_write(tv[i].k, 1'b0, {24'h0, tv[i].d}, 4'h1, nw);
            chk("tx_nowait", nw, 0);
            capture12(tv[i].k, got);
            chk("tx_frame", {20'h0, got}, {20'h0, tv[i].exp});
        end

        // back-to-back "Hello," with a monitor on the line
        found = 1'b0;
        mb = '1;
        fork
            begin
                for (int i = 0; i < 6; i++) bus_write(0, 1'b0, {24'h0, hello[i]}, 4'h1, hw[i]);
            end
            begin
                for (int c = 0; c < 100 && !found; c++) begin
                    @(negedge clk);
                    if (!txd[0]) found = 1'b1;
                end
                mb[0] = txd[0];
                for (int i = 1; i < 61; i++) begin
                    @(negedge clk);
                    mb[i] = txd[0];
                end
            end
        join
        chk("hello_start_seen", {31'b0, found}, 32'h1);
        chk("hello_wait0", hw[0], 0);
        chk("hello_wait1", hw[1], 0);
        chk("hello_wait2_stalled", {31'b0, (hw[2] > 0 && hw[2] < 20)}, 32'h1);
        fr_bad = 0;
        for (int j = 0; j < 6; j++) begin
            if (mb[10*j] !== 1'b0 || mb[10*j+9] !== 1'b1) fr_bad++;
            chk("hello_char", {24'h0, mb[10*j+1 +: 8]}, {24'h0, hello[j]});
        end
        chk("hello_framing_errors", fr_bad, 0);
        chk("hello_idle_after", {31'b0, mb[60]}, 32'h1);
        repeat (4) @(posedge clk);
        #1;

        // byteenable[0]=0 write has no effect
        bus_write(0, 1'b0, 32'h55, 4'h0, nw);
        all1 = 1'b1;
        for (int j = 0; j < 12; j++) begin
            all1 &= txd[0];
            @(posedge clk); #1;
        end
        chk("be0_no_tx", {31'b0, all1}, 32'h1);
        bus_read(0, 1'b1, 4'hF, q); chk("be0_status", q, 32'h1);

        // busy status, then asynchronous reset mid-frame
        bus_write(0, 1'b0, 32'h00, 4'h1, nw);
        bus_read(0, 1'b1, 4'hF, q); chk("busy_status", q, 32'h3);
        chk("midframe_low", {31'b0, txd[0]}, 32'h0);
        #3 rst = 1'b0;
        #1 chk("reset_abort_txd", {31'b0, txd[0]}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus_read(0, 1'b1, 4'hF, q); chk("after_reset_status", q, 32'h1);
        bus_write(0, 1'b0, 32'h48, 4'h1, nw);
        capture12(0, got);
        chk("after_reset_frame", {20'h0, got}, {20'h0, 3'b111, 8'h48, 1'b0});

        // RX at 4 clocks per bit: glitch on the start bit is ignored
        rxd[3] = 1'b0;
        @(posedge clk); #1;
        rxd[3] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus_read(3, 1'b1, 4'hF, q); chk("rx_glitch_status", q, 32'h1);

        send_rx(8'h6F, 1'b1);
        bus_read(3, 1'b0, 4'h1, q); chk("rx_6f_read", q, 32'h16F);
        bus_read(3, 1'b0, 4'h1, q); chk("rx_6f_reread", q, 32'h06F);

        send_rx(8'h33, 1'b0);
        bus_read(3, 1'b1, 4'hF, q); chk("rx_ferr_status", q, 32'h11);
        bus_read(3, 1'b0, 4'h0, q); chk("rx_ferr_data_kept", q, 32'h06F);
        bus_write(3, 1'b1, 32'h10, 4'hF, nw);
        bus_read(3, 1'b1, 4'hF, q); chk("rx_ferr_cleared", q, 32'h1);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(3, 1'b1, 4'hF, q); chk("rx_overrun_status", q, 32'h0D);
        bus_read(3, 1'b0, 4'h1, q); chk("rx_overrun_data", q, 32'h122);
        bus_write(3, 1'b1, 32'h08, 4'hF, nw);
        bus_read(3, 1'b1, 4'hF, q); chk("rx_overrun_cleared", q, 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameters (name, default, meaning), all SHALL be supported:
- AAW, 1, Avalon address width.
- ADW, 32, Avalon data width.
- BYTESIZE, 8, data bits per frame (5..8).
- PARITY, "NONE", "NONE", "ODD" or "EVEN".
- STOPSIZE, 1, stop bits (1 or 2).
- BAUD_DIV, 1, clock cycles per bit (>=1).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- avalon_read, in, 1, read request.
- avalon_write, in, 1, write request.
- avalon_address, in, AAW, register address.
- avalon_byteenable, in, ADW/8, byte enables.
- avalon_writedata, in, ADW, write data.
- avalon_readdata, out, ADW, read data.
- avalon_waitrequest, out, 1, stalls the current transfer.
- uart_rxd, in, 1, serial input.
- uart_txd, out, 1, serial output.

Function
REQ-003 Transfer completes on a rising clk edge where (avalon_read|avalon_write) & ~avalon_waitrequest; master holds all signals until then.
REQ-004 avalon_waitrequest SHALL be combinational: 1 only for a write to address 0 while the TX holding register is full; 0 otherwise (reads never wait).
REQ-005 avalon_readdata SHALL be combinational and valid in the completing cycle; unused bits read 0.
REQ-006 Address 0 write with byteenable[0]=1: writedata[BYTESIZE-1:0] loaded into the TX holding register, which becomes full; byteenable[0]=0 completes with no effect.
REQ-007 Address 0 read: [7:0]=RX data, [8]=rx_valid; a completed read with byteenable[0]=1 clears rx_valid.
REQ-008 Address 1 read: [0]=tx_ready (holding empty), [1]=tx_busy (shifter active), [2]=rx_valid, [3]=rx_overrun, [4]=rx_frame_err.
REQ-009 Address 1 write: writedata bit 3/4 = 1 clears rx_overrun/rx_frame_err; other bits ignored.
REQ-010 TX: when the shifter is idle or finishing its last stop bit and the holding register is full, the holding register moves to the shifter on that edge and empties.
REQ-011 TX frame: start 0, BYTESIZE data bits LSB first, optional parity (ODD: odd count of ones over data+parity; EVEN: even count), then STOPSIZE 1s; each bit lasts exactly BAUD_DIV cycles.
REQ-012 Back-to-back frames SHALL have no idle gap; uart_txd idles at 1.
REQ-013 Start bit SHALL appear on uart_txd the cycle after the write completes when the shifter is idle (registered output).
REQ-014 RX: uart_rxd passes through a 2-flop synchronizer; a falling edge while idle starts a frame; each bit is sampled at cycle BAUD_DIV/2 (integer division) of its bit period.
REQ-015 RX: start bit sampled 1 is treated as a glitch and RX returns to idle; parity mismatch or stop bit sampled 0 sets rx_frame_err and the byte is discarded.
REQ-016 RX: a good byte loads RX data and sets rx_valid; if rx_valid is already set, the data is overwritten and rx_overrun is set.
REQ-017 When an RX byte write and a clearing read occur in the same cycle, rx_valid remains 1 and the new data is stored.

Reset
REQ-018 When rst=0 (asynchronous): uart_txd=1; TX holding register empty; TX/RX idle; rx_valid, rx_overrun and rx_frame_err =0; RX data=0.
REQ-019 Reset mid-frame SHALL abort the frame immediately (uart_txd=1); after release the block accepts new writes normally.

Verification
REQ-020 Default parameters, write 0x48 ("H") to address 0: uart_txd=0,0,0,0,1,0,0,1,0,1 for one clock each, then 1.
REQ-021 Write "H","e","l","l","o","," back-to-back: the first two writes complete without wait; later writes stall until the holding register empties; each frame is 10 cycles with no gaps and the monitor decodes "Hello,".
REQ-022 PARITY="EVEN", write 0x48: the parity bit is 0 and the frame is 11 cycles; with PARITY="ODD" the parity bit is 1.
REQ-023 Drive uart_rxd with a valid 0x6F frame at BAUD_DIV=4: address 0 reads 0x0000016F, and a second read returns bit 8 = 0.
REQ-024 RX frame with stop bit 0: address 1 bit 4 = 1 and rx_valid stays 0; writing 0x10 to address 1 clears bit 4.
REQ-025 Two good RX frames with no read in between: address 1 reads bits [3:2]=11, and RX data holds the second byte.
